// File: rtl/onehot_priority_encoder_seq.sv
// Sequential priority encoder: accepts a multi-hot vector, then emits the index of each
// set bit (lowest first) as one output beat per handshake; an all-zero vector gives one "none" beat.
module onehot_priority_encoder_seq #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned IDXW = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_vec,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last,
  output logic              out_none,
  output logic [IDXW:0]     out_count
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDXW:0]    count_q, count_d;
  logic             none_q, none_d;

  logic [IDXW-1:0]  low_idx;
  logic [IDXW:0]    popcnt;
  logic             at_most_one;

  always_comb begin
    low_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = IDXW'(i);
    end
  end

  always_comb begin
    popcnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      popcnt = popcnt + {{IDXW{1'b0}}, in_vec[i]};
    end
  end

  // Clearing the lowest set bit leaves zero exactly when at most one bit was set.
  assign at_most_one = ((pending_q & (pending_q - WIDTH'(1))) == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StEmit;
      StEmit: if (out_ready && at_most_one) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;
    out_count = '0;
    unique case (state_q)
      StIdle: in_ready = 1'b1;
      StEmit: begin
        out_valid = 1'b1;
        out_idx   = low_idx;
        out_last  = at_most_one;
        out_none  = none_q;
        out_count = count_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    pending_d = pending_q;
    count_d   = count_q;
    none_d    = none_q;
    if (state_q == StIdle && in_valid) begin
      pending_d = in_vec;
      count_d   = popcnt;
      none_d    = (in_vec == '0);
    end else if (state_q == StEmit && out_ready) begin
      pending_d = pending_q & (pending_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      count_q   <= '0;
      none_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      none_q    <= none_d;
    end
  end

endmodule
